// File: rtl/mux_skid_n.sv
// N-way source selector feeding a two-entry skid buffer with valid/ready on both sides.
// The select index travels with the data; out-of-range selects store zero data and raise a sticky error.
module mux_skid_n #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int SELW  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NSRC*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]       in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_src,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic                  sel_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] head_data_q;
  logic [SELW-1:0]  head_src_q;
  logic [WIDTH-1:0] skid_data_q;
  logic [SELW-1:0]  skid_src_q;
  logic             err_q;

  logic [WIDTH-1:0] sel_data;
  logic             sel_ok;
  logic             accept;
  logic             deliver;

  // Loop compare keeps the part-select in range even when NSRC < 2**SELW.
  always_comb begin
    sel_data = '0;
    sel_ok   = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (in_sel == SELW'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_ok   = 1'b1;
      end
    end
  end

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_data_q;
  assign out_src   = head_src_q;
  assign sel_err   = err_q;

  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      head_data_q <= '0;
      head_src_q  <= '0;
      skid_data_q <= '0;
      skid_src_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      // Set beats clear, and an errored accept still counts during a flush.
      if (accept && !sel_ok) begin
        err_q <= 1'b1;
      end else if (clr_err) begin
        err_q <= 1'b0;
      end

      if (flush) begin
        state_q <= EMPTY;
      end else begin
        case (state_q)
          EMPTY: begin
            if (accept) begin
              head_data_q <= sel_data;
              head_src_q  <= in_sel;
              state_q     <= ONE;
            end
          end
          ONE: begin
            case ({accept, deliver})
              2'b10: begin
                skid_data_q <= sel_data;
                skid_src_q  <= in_sel;
                state_q     <= TWO;
              end
              2'b01: state_q <= EMPTY;
              2'b11: begin
                head_data_q <= sel_data;
                head_src_q  <= in_sel;
              end
              default: ;
            endcase
          end
          TWO: begin
            if (deliver) begin
              head_data_q <= skid_data_q;
              head_src_q  <= skid_src_q;
              state_q     <= ONE;
            end
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mux_skid_n.sv
// Directed bench for mux_skid_n: a default 4-source instance and a 3-source instance for select errors.
module tb_mux_skid_n;

  logic         clk;
  logic         reset;

  logic [127:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_src;
  logic         out_valid;
  logic         out_ready;
  logic         flush;
  logic         clr_err;
  logic         sel_err;

  logic [95:0]  b_in_data;
  logic [1:0]   b_in_sel;
  logic         b_in_valid;
  logic         b_in_ready;
  logic [31:0]  b_out_data;
  logic [1:0]   b_out_src;
  logic         b_out_valid;
  logic         b_out_ready;
  logic         b_flush;
  logic         b_clr_err;
  logic         b_sel_err;

  int errors = 0;
  int checks = 0;

  mux_skid_n #(.WIDTH(32), .NSRC(4), .SELW(2)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .clr_err(clr_err), .sel_err(sel_err)
  );

  mux_skid_n #(.WIDTH(32), .NSRC(3), .SELW(2)) dut_b (
    .clk(clk), .reset(reset),
    .in_data(b_in_data), .in_sel(b_in_sel), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_src(b_out_src), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .flush(b_flush), .clr_err(b_clr_err), .sel_err(b_sel_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic load_sources(input logic [31:0] base);
    for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = base + 32'(k);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || out_src !== 2'd0 || sel_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b r=%b d=%h s=%0d e=%b exp v=0 r=1 d=0 s=0 e=0",
               out_valid, in_ready, out_data, out_src, sel_err);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    load_sources(32'h1000_0000);
    for (int i = 0; i < 4; i++) begin
      in_sel = 2'(i);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready[%0d] got %b exp 1", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== (32'h1000_0000 + 32'(i)) || out_src !== 2'(i)) begin
        errors++;
        $display("FAIL stream_item[%0d] got v=%b d=%h s=%0d exp v=1 d=%h s=%0d",
                 i, out_valid, out_data, out_src, 32'h1000_0000 + 32'(i), i);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain got v=%b exp 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    load_sources(32'hA000_0000);
    in_sel = 2'd1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_data !== 32'hA000_0001) begin
      errors++;
      $display("FAIL bp_after_a got r=%b d=%h exp r=1 d=a0000001", in_ready, out_data);
    end
    load_sources(32'hB000_0000);
    in_sel = 2'd2;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_data !== 32'hA000_0001) begin
      errors++;
      $display("FAIL bp_after_b got r=%b d=%h exp r=0 d=a0000001", in_ready, out_data);
    end
    load_sources(32'hC000_0000);
    in_sel = 2'd0;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hA000_0001 || out_src !== 2'd1) begin
      errors++;
      $display("FAIL bp_hold got r=%b v=%b d=%h s=%0d exp r=0 v=1 d=a0000001 s=1",
               in_ready, out_valid, out_data, out_src);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hB000_0002 || out_src !== 2'd2 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_b got v=%b d=%h s=%0d r=%b exp v=1 d=b0000002 s=2 r=1",
               out_valid, out_data, out_src, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hC000_0000 || out_src !== 2'd0) begin
      errors++;
      $display("FAIL bp_release_c got v=%b d=%h s=%0d exp v=1 d=c0000000 s=0",
               out_valid, out_data, out_src);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got v=%b exp 0", out_valid);
    end
  endtask

  task automatic test_one_state();
    logic [31:0] base;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    load_sources(32'h5000_0000);
    in_sel = 2'd3;
    tick();
    for (int i = 0; i < 8; i++) begin
      base = 32'h6000_0000 + (32'(i) << 8);
      load_sources(base);
      in_sel = 2'(i % 4);
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== base + 32'(i % 4) || out_src !== 2'(i % 4)) begin
        errors++;
        $display("FAIL one_track[%0d] got v=%b r=%b d=%h s=%0d exp v=1 r=1 d=%h s=%0d",
                 i, out_valid, in_ready, out_data, out_src, base + 32'(i % 4), i % 4);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL one_drain got v=%b exp 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    load_sources(32'h7000_0000);
    in_sel = 2'd0;
    tick();
    in_sel = 2'd1;
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_full got r=%b exp 0", in_ready);
    end
    load_sources(32'hF000_0000);
    in_sel = 2'd2;
    flush  = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_two got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_ghost got v=%b d=%h exp v=0", out_valid, out_data);
    end
    // Accept in the flush cycle from ONE: the item must be dropped.
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_sel    = 2'd3;
    tick();
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_one_accept got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_sel_err();
    for (int k = 0; k < 3; k++) b_in_data[k*32 +: 32] = 32'h1111_1111 * 32'(k + 1);
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_sel    = 2'd3;
    tick();
    b_in_valid = 1'b0;
    checks++;
    if (b_out_valid !== 1'b1 || b_out_data !== 32'h0 || b_out_src !== 2'd3 || b_sel_err !== 1'b1) begin
      errors++;
      $display("FAIL err_set got v=%b d=%h s=%0d e=%b exp v=1 d=0 s=3 e=1",
               b_out_valid, b_out_data, b_out_src, b_sel_err);
    end
    tick();
    tick();
    checks++;
    if (b_sel_err !== 1'b1 || b_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky got e=%b v=%b exp e=1 v=0", b_sel_err, b_out_valid);
    end
    b_clr_err = 1'b1;
    tick();
    b_clr_err = 1'b0;
    checks++;
    if (b_sel_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got %b exp 0", b_sel_err);
    end
    b_in_valid = 1'b1;
    b_in_sel   = 2'd3;
    b_clr_err  = 1'b1;
    tick();
    b_clr_err = 1'b0;
    checks++;
    if (b_sel_err !== 1'b1) begin
      errors++;
      $display("FAIL err_set_wins got %b exp 1", b_sel_err);
    end
    b_in_sel  = 2'd2;
    b_clr_err = 1'b1;
    tick();
    b_clr_err  = 1'b0;
    b_in_valid = 1'b0;
    checks++;
    if (b_sel_err !== 1'b0 || b_out_data !== 32'h3333_3333 || b_out_src !== 2'd2) begin
      errors++;
      $display("FAIL err_valid_sel got e=%b d=%h s=%0d exp e=0 d=33333333 s=2",
               b_sel_err, b_out_data, b_out_src);
    end
    tick();
    b_in_valid = 1'b1;
    b_in_sel   = 2'd3;
    b_flush    = 1'b1;
    tick();
    b_flush    = 1'b0;
    b_in_valid = 1'b0;
    checks++;
    if (b_sel_err !== 1'b1 || b_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_in_flush got e=%b v=%b exp e=1 v=0", b_sel_err, b_out_valid);
    end
  endtask

  task automatic test_async_reset();
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    load_sources(32'h9000_0000);
    in_sel      = 2'd1;
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_sel    = 2'd3;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0 || b_in_ready !== 1'b0 || b_sel_err !== 1'b1) begin
      errors++;
      $display("FAIL areset_setup got r=%b br=%b be=%b exp r=0 br=0 be=1", in_ready, b_in_ready, b_sel_err);
    end
    in_valid   = 1'b0;
    b_in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1 ||
        b_out_valid !== 1'b0 || b_sel_err !== 1'b0 || b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_async got v=%b d=%h r=%b bv=%b be=%b br=%b exp v=0 d=0 r=1 bv=0 be=0 br=1",
               out_valid, out_data, in_ready, b_out_valid, b_sel_err, b_in_ready);
    end
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_after got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    end
  endtask

  initial begin
    in_data     = '0;
    in_sel      = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    flush       = 1'b0;
    clr_err     = 1'b0;
    b_in_data   = '0;
    b_in_sel    = '0;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;
    b_flush     = 1'b0;
    b_clr_err   = 1'b0;

    test_reset();
    test_stream();
    test_backpressure();
    test_one_state();
    test_flush();
    test_sel_err();
    test_async_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
